// File: rtl/addsub_pkg.sv
// Shared defaults, segment width and flag bundle for the pipelined add/sub block.
package addsub_pkg;

    localparam int unsigned DEFAULT_WIDTH  = 32;
    localparam int unsigned DEFAULT_STAGES = 4;
    localparam int unsigned SEG_W          = DEFAULT_WIDTH / DEFAULT_STAGES;

    typedef struct packed {
        logic overflow;
        logic zero;
        logic negative;
    } addsubFlags_t;

    // Signed overflow uses the effective (possibly inverted) second operand.
    function automatic addsubFlags_t calcFlags(input logic aMsb, input logic bMsb,
                                               input logic sumMsb, input logic isZero);
        addsubFlags_t f;
        f.overflow = (aMsb == bMsb) && (sumMsb != aMsb);
        f.zero     = isZero;
        f.negative = sumMsb;
        return f;
    endfunction

endpackage

// File: rtl/addsub_segment.sv
// Combinational slice of the carry chain: WIDTH-bit sum with carry in and out.
module addsub_segment
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = SEG_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryIn,
    output logic [WIDTH-1:0] sum,
    output logic             carryOut
);

    logic [WIDTH:0] full;

    assign full     = {1'b0, a} + {1'b0, b} + (WIDTH + 1)'(carryIn);
    assign sum      = full[WIDTH-1:0];
    assign carryOut = full[WIDTH];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor with the carry chain split into STAGES registered segments.
// Optional flag outputs (overflow, zero, negative) are built only with PIPELINED_ADDSUB_FLAGS_EN.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    // WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH.
    localparam int unsigned SEG_LEN = WIDTH / STAGES;

    logic              stall;
    logic              advance;
    logic [STAGES-1:0] validPipe;

    assign stall     = validPipe[STAGES-1] && !out_ready;
    assign advance   = !stall;
    assign in_ready  = advance;
    assign out_valid = validPipe[STAGES-1];

    // Bit k marks the register bank behind segment k; the top bit is the output bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validPipe <= '0;
        end else if (advance) begin
            validPipe <= (validPipe << 1) | STAGES'(in_valid);
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned REM  = WIDTH - k * SEG_LEN;
        localparam int unsigned DONE = k * SEG_LEN;

        logic [REM-1:0]          aSrc;
        logic [REM-1:0]          bSrc;
        logic                    carrySrc;
        logic [SEG_LEN-1:0]      segSum;
        logic                    segCarry;
        logic [DONE+SEG_LEN-1:0] sumFull;

        if (k == 0) begin : g_head
            assign aSrc     = op_a;
            assign bSrc     = sub ? ~op_b : op_b;
            assign carrySrc = carry_in ^ sub;
            assign sumFull  = segSum;
        end else begin : g_body
            // Only the still-unresolved upper operand bits travel with the beat.
            logic [REM-1:0]  aQ;
            logic [REM-1:0]  bQ;
            logic            carryQ;
            logic [DONE-1:0] sumQ;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    aQ     <= '0;
                    bQ     <= '0;
                    carryQ <= 1'b0;
                    sumQ   <= '0;
                end else if (advance) begin
                    aQ     <= g_stage[k-1].aSrc[REM+SEG_LEN-1:SEG_LEN];
                    bQ     <= g_stage[k-1].bSrc[REM+SEG_LEN-1:SEG_LEN];
                    carryQ <= g_stage[k-1].segCarry;
                    sumQ   <= g_stage[k-1].sumFull;
                end
            end

            assign aSrc     = aQ;
            assign bSrc     = bQ;
            assign carrySrc = carryQ;
            assign sumFull  = {segSum, sumQ};
        end

        addsub_segment #(
            .WIDTH(SEG_LEN)
        ) u_segment (
            .a       (aSrc[SEG_LEN-1:0]),
            .b       (bSrc[SEG_LEN-1:0]),
            .carryIn (carrySrc),
            .sum     (segSum),
            .carryOut(segCarry)
        );
    end

    // Output bank captures the fully resolved sum from the last segment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            carry_out <= 1'b0;
        end else if (advance) begin
            sum       <= g_stage[STAGES-1].sumFull;
            carry_out <= g_stage[STAGES-1].segCarry;
        end
    end

`ifdef PIPELINED_ADDSUB_FLAGS_EN
    addsubFlags_t flagsQ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flagsQ <= '0;
        end else if (advance) begin
            flagsQ <= calcFlags(g_stage[STAGES-1].aSrc[SEG_LEN-1],
                                g_stage[STAGES-1].bSrc[SEG_LEN-1],
                                g_stage[STAGES-1].segSum[SEG_LEN-1],
                                ~|g_stage[STAGES-1].sumFull);
        end
    end

    assign overflow = flagsQ.overflow;
    assign zero     = flagsQ.zero;
    assign negative = flagsQ.negative;
`else
    assign overflow = 1'b0;
    assign zero     = 1'b0;
    assign negative = 1'b0;
`endif

endmodule
